// File: rtl/byte_strip_pkg.sv
// Shared definitions for the lane byte striper: K-code values, FSM states, K-code check.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   STP/SDP/END/EDB/SKP/IDL/FTS/COM/PAD  8-bit K-symbol codes
//   strip_state_e                        striper FSM state encoding
//   is_valid_k()                         1 when a K byte is one of the known codes
package byte_strip_pkg;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] FTS = 8'h3C;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] PAD = 8'hF7;

  typedef enum logic [1:0] {
    STRIPE    = 2'd0,
    PAD_FLUSH = 2'd1,
    OS_BCAST  = 2'd2
  } strip_state_e;

  function automatic logic is_valid_k(input logic [7:0] b);
    case (b)
      STP, SDP, END, EDB, SKP, IDL, FTS, COM, PAD: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/strip_out_reg.sv
// One-entry valid/ready output register holding a full lane word.
// Latency: 1 cycle from load to out_valid.
// Backpressure: contents held while out_valid & !out_ready; loadable = !out_valid | out_ready.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   load, din[W]         write a new word (caller only asserts load when loadable)
//   loadable             register can take a word this cycle
//   dout[W], out_valid   registered word and its valid
//   out_ready            downstream consumes the word
module strip_out_reg #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         loadable,
  output logic [W-1:0] dout,
  output logic         out_valid,
  input  logic         out_ready
);

  assign loadable = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      dout      <= din;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_strip_multi.sv
// Byte striper: DLL byte stream round-robin onto NUM_LANES lanes; COM-led ordered sets broadcast to all lanes.
// Latency: a word is valid 1 cycle after its last byte (or the COM/PAD event) is accepted.
// Backpressure: IN_READY drops when the word being completed cannot enter the full output register,
//               during PAD_FLUSH, and in OS_BCAST whenever the output register is not loadable.
//
// Ports:
//   CLK, RESET_L                  clock, synchronous active-low reset
//   D, DK, IN_VALID, IN_READY     input byte, K flag, handshake
//   LANE_DATA, LANE_DK            lane i byte at [8*i+7:8*i], K flag at [i]
//   OUT_VALID, OUT_READY          output word handshake
//   ERROR_DLL                     one-cycle pulse after an accepted protocol-error byte
// Optional build macro BYTE_STRIPE_ERR_EN enables the error decode; without it ERROR_DLL is 0.
module byte_strip_multi
  import byte_strip_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int OS_LEN    = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_L,
  input  logic [7:0]             D,
  input  logic                   DK,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [8*NUM_LANES-1:0] LANE_DATA,
  output logic [NUM_LANES-1:0]   LANE_DK,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   ERROR_DLL
);

  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CW = $clog2(OS_LEN + 1);
  localparam int WW = 9 * NUM_LANES;
  localparam logic [PW-1:0] LAST    = PW'(NUM_LANES - 1);
  localparam logic [CW-1:0] OS_LAST = CW'(OS_LEN - 1);

  strip_state_e           state;
  logic [PW-1:0]          ptr;
  logic [CW-1:0]          os_cnt;    // ordered-set symbols emitted so far, COM included
  logic                   pad_pend;  // pad word still owed before the pending COM
  logic [7:0]             slot_d [NUM_LANES];
  logic [NUM_LANES-1:0]   slot_k;

  logic                   loadable;
  logic                   load;
  logic [WW-1:0]          load_word;
  logic [WW-1:0]          out_word;
  logic                   in_ready_c;
  logic                   accept;
  logic                   is_com;
  logic                   at_last;

  logic [8*NUM_LANES-1:0] pad_d, strp_d, wd;
  logic [NUM_LANES-1:0]   pad_k, strp_k, wk;

  assign is_com  = DK && (D == COM);
  assign at_last = (ptr == LAST);

  always_comb begin
    in_ready_c = 1'b0;
    case (state)
      STRIPE:    in_ready_c = at_last ? loadable : 1'b1;
      PAD_FLUSH: in_ready_c = 1'b0;
      OS_BCAST:  in_ready_c = loadable;
      default:   in_ready_c = 1'b0;
    endcase
  end

  assign IN_READY = RESET_L && in_ready_c;
  assign accept   = IN_VALID && IN_READY;

  // Candidate words: the striped word completed by the current byte, and the
  // padded word (slots below ptr kept, the rest PAD).
  always_comb begin
    pad_d  = '0;
    pad_k  = '0;
    strp_d = '0;
    strp_k = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (PW'(i) < ptr) begin
        pad_d[8*i +: 8] = slot_d[i];
        pad_k[i]        = slot_k[i];
      end else begin
        pad_d[8*i +: 8] = PAD;
        pad_k[i]        = 1'b1;
      end
      if (i == NUM_LANES - 1) begin
        strp_d[8*i +: 8] = D;
        strp_k[i]        = DK;
      end else begin
        strp_d[8*i +: 8] = slot_d[i];
        strp_k[i]        = slot_k[i];
      end
    end
  end

  always_comb begin
    load = 1'b0;
    wd   = '0;
    wk   = '0;
    case (state)
      STRIPE: begin
        if (accept) begin
          if (is_com) begin
            // If the output register is busy the word is produced later from PAD_FLUSH.
            load = loadable;
            if (ptr == '0) begin
              wd = {NUM_LANES{COM}};
              wk = '1;
            end else begin
              wd = pad_d;
              wk = pad_k;
            end
          end else if (at_last) begin
            load = 1'b1;
            wd   = strp_d;
            wk   = strp_k;
          end
        end
      end
      PAD_FLUSH: begin
        if (loadable) begin
          load = 1'b1;
          if (pad_pend) begin
            wd = pad_d;
            wk = pad_k;
          end else begin
            wd = {NUM_LANES{COM}};
            wk = '1;
          end
        end
      end
      OS_BCAST: begin
        if (accept) begin
          load = 1'b1;
          wd   = {NUM_LANES{D}};
          wk   = {NUM_LANES{DK}};
        end
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  assign load_word = {wk, wd};

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state    <= STRIPE;
      ptr      <= '0;
      os_cnt   <= '0;
      pad_pend <= 1'b0;
      slot_k   <= '0;
      for (int i = 0; i < NUM_LANES; i++) slot_d[i] <= '0;
    end else begin
      case (state)
        STRIPE: begin
          if (accept) begin
            if (is_com) begin
              os_cnt <= CW'(1);
              if (ptr == '0) begin
                pad_pend <= 1'b0;
                state    <= loadable ? OS_BCAST : PAD_FLUSH;
              end else begin
                // ptr is kept while the pad word is still owed: it masks the pad fill.
                pad_pend <= !loadable;
                state    <= PAD_FLUSH;
                if (loadable) ptr <= '0;
              end
            end else if (at_last) begin
              ptr <= '0;
            end else begin
              for (int i = 0; i < NUM_LANES; i++) begin
                if (PW'(i) == ptr) begin
                  slot_d[i] <= D;
                  slot_k[i] <= DK;
                end
              end
              ptr <= ptr + PW'(1);
            end
          end
        end
        PAD_FLUSH: begin
          if (loadable) begin
            if (pad_pend) begin
              pad_pend <= 1'b0;
              ptr      <= '0;
            end else begin
              state <= OS_BCAST;
            end
          end
        end
        OS_BCAST: begin
          if (accept) begin
            if (is_com) begin
              os_cnt <= CW'(1);  // a fresh ordered set starts over
            end else if (os_cnt == OS_LAST) begin
              state  <= STRIPE;
              ptr    <= '0;
              os_cnt <= '0;
            end else begin
              os_cnt <= os_cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= STRIPE;
        end
      endcase
    end
  end

  strip_out_reg #(.W(WW)) u_out_reg (
    .clk       (CLK),
    .rst_n     (RESET_L),
    .load      (load),
    .din       (load_word),
    .loadable  (loadable),
    .dout      (out_word),
    .out_valid (OUT_VALID),
    .out_ready (OUT_READY)
  );

  assign LANE_DATA = out_word[8*NUM_LANES-1:0];
  assign LANE_DK   = out_word[WW-1 -: NUM_LANES];

`ifdef BYTE_STRIPE_ERR_EN
  logic err_q;

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && ((DK && !is_valid_k(D)) || (state == OS_BCAST && !DK));
    end
  end

  assign ERROR_DLL = err_q;
`else
  assign ERROR_DLL = 1'b0;
`endif

endmodule

// File: tb/tb_byte_strip_multi.sv
module tb_byte_strip_multi;

`ifdef BYTE_STRIPE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  // 4-lane instance
  logic [7:0]  d;
  logic        dk, in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] lane_data;
  logic [3:0]  lane_dk;

  // 3-lane instance
  logic [7:0]  d3;
  logic        dk3, in_valid3, in_ready3, out_valid3, err3;
  logic        out_ready3 = 1'b1;
  logic [23:0] lane_data3;
  logic [2:0]  lane_dk3;

  // 1-lane instance
  logic [7:0]  d1;
  logic        dk1, in_valid1, in_ready1, out_valid1, err1;
  logic        out_ready1 = 1'b1;
  logic [7:0]  lane_data1;
  logic [0:0]  lane_dk1;

  int errors = 0;
  int checks = 0;

  logic [35:0] exp_q[$];
  logic [26:0] exp3_q[$];

  byte_strip_multi #(.NUM_LANES(4), .OS_LEN(4)) dut (
    .CLK(clk), .RESET_L(rst_l), .D(d), .DK(dk), .IN_VALID(in_valid), .IN_READY(in_ready),
    .LANE_DATA(lane_data), .LANE_DK(lane_dk), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .ERROR_DLL(err));

  byte_strip_multi #(.NUM_LANES(3), .OS_LEN(4)) dut3 (
    .CLK(clk), .RESET_L(rst_l), .D(d3), .DK(dk3), .IN_VALID(in_valid3), .IN_READY(in_ready3),
    .LANE_DATA(lane_data3), .LANE_DK(lane_dk3), .OUT_VALID(out_valid3), .OUT_READY(out_ready3),
    .ERROR_DLL(err3));

  byte_strip_multi #(.NUM_LANES(1), .OS_LEN(4)) dut1 (
    .CLK(clk), .RESET_L(rst_l), .D(d1), .DK(dk1), .IN_VALID(in_valid1), .IN_READY(in_ready1),
    .LANE_DATA(lane_data1), .LANE_DK(lane_dk1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
    .ERROR_DLL(err1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] bc4(input logic [7:0] b);
    return {4'hF, {4{b}}};
  endfunction

  function automatic logic [26:0] bc3(input logic [7:0] b);
    return {3'h7, {3{b}}};
  endfunction

  // Each send starts and ends on a falling edge; the byte is taken at the rising edge between.
  task automatic send(input logic [7:0] b, input logic k);
    int n = 0;
    d = b; dk = k; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin @(negedge clk); #1; n++; end
    check("send4_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] b, input logic k);
    int n = 0;
    d3 = b; dk3 = k; in_valid3 = 1'b1;
    #1;
    while (!in_ready3 && n < 100) begin @(negedge clk); #1; n++; end
    check("send3_ready", in_ready3, 1'b1);
    @(negedge clk);
    in_valid3 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b, input logic k);
    int n = 0;
    d1 = b; dk1 = k; in_valid1 = 1'b1;
    #1;
    while (!in_ready1 && n < 100) begin @(negedge clk); #1; n++; end
    check("send1_ready", in_ready1, 1'b1);
    @(negedge clk);
    in_valid1 = 1'b0;
    check("n1_valid", out_valid1, 1'b1);
    check("n1_word", {lane_dk1, lane_data1}, {k, b});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp3_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
    check("drain4_empty", exp_q.size(), 0);
    check("drain3_empty", exp3_q.size(), 0);
    @(negedge clk);
  endtask

  // Scoreboard monitors: a word is compared in the cycle its handshake completes.
  always @(negedge clk) begin
    #1;
    if (rst_l && out_valid && out_ready) begin
      check("w4_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("w4_word", {lane_dk, lane_data}, exp_q.pop_front());
    end
    if (rst_l && out_valid3 && out_ready3) begin
      check("w3_expected", exp3_q.size() != 0, 1'b1);
      if (exp3_q.size() != 0) check("w3_word", {lane_dk3, lane_data3}, exp3_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0;
    d = '0; dk = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    d3 = '0; dk3 = 1'b0; in_valid3 = 1'b0;
    d1 = '0; dk1 = 1'b0; in_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_lane_data", lane_data, 32'h0);
    check("rst_lane_dk", lane_dk, 4'h0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_err", err, 1'b0);
    rst_l = 1'b1;
    @(negedge clk);

    // Plain striping, latency 1 after the 4th byte
    exp_q.push_back({4'h0, 32'h04030201});
    exp_q.push_back({4'h0, 32'h08070605});
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0);
      if (i == 3) check("t1_no_early_word", out_valid, 1'b0);
      if (i == 4) begin
        check("t1_lat_valid", out_valid, 1'b1);
        check("t1_lat_word", {lane_dk, lane_data}, {4'h0, 32'h04030201});
      end
    end

    // Partial word padded before an ordered set
    exp_q.push_back({4'b1100, 32'hF7F72211});
    exp_q.push_back(bc4(8'hBC));
    repeat (3) exp_q.push_back(bc4(8'h1C));
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'hBC, 1'b1);
    check("t2_flush_in_ready", in_ready, 1'b0);
    check("t2_pad_word", {lane_dk, lane_data}, {4'b1100, 32'hF7F72211});
    repeat (3) send(8'h1C, 1'b1);

    // COM inside an ordered set restarts the count
    exp_q.push_back(bc4(8'hBC));
    exp_q.push_back(bc4(8'h1C));
    exp_q.push_back(bc4(8'hBC));
    repeat (3) exp_q.push_back(bc4(8'h1C));
    exp_q.push_back({4'h0, 32'h34333231});
    send(8'hBC, 1'b1); send(8'h1C, 1'b1);
    send(8'hBC, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
    send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h33, 1'b0); send(8'h34, 1'b0);
    drain();

    // Output stall: word held, 4th byte refused, nothing lost afterwards
    out_ready = 1'b0;
    exp_q.push_back({4'h0, 32'hA4A3A2A1});
    exp_q.push_back({4'h0, 32'hA8A7A6A5});
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
    send(8'hA5, 1'b0); send(8'hA6, 1'b0); send(8'hA7, 1'b0);
    for (int c = 0; c < 7; c++) begin
      check("t3_stall_in_ready", in_ready, 1'b0);
      check("t3_stall_valid", out_valid, 1'b1);
      check("t3_stall_hold", {lane_dk, lane_data}, {4'h0, 32'hA4A3A2A1});
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(8'hA8, 1'b0);
    drain();

    // Reset in the middle of an ordered set
    exp_q.push_back(bc4(8'hBC));
    exp_q.push_back(bc4(8'h1C));
    send(8'hBC, 1'b1);
    send(8'h1C, 1'b1);
    drain();
    rst_l = 1'b0;
    @(negedge clk);
    check("t4_rst_in_ready", in_ready, 1'b0);
    check("t4_rst_valid", out_valid, 1'b0);
    check("t4_rst_data", lane_data, 32'h0);
    rst_l = 1'b1;
    @(negedge clk);
    check("t4_first_valid", out_valid, 1'b0);
    exp_q.push_back({4'h0, 32'h44434241});
    send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b0);
    check("t4_lat_valid", out_valid, 1'b1);

    // Unknown K symbol and data byte inside an ordered set
    exp_q.push_back({4'b0001, 32'h03020155});
    exp_q.push_back(bc4(8'hBC));
    exp_q.push_back({4'h0, 32'h77777777});
    repeat (2) exp_q.push_back(bc4(8'h1C));
    send(8'h55, 1'b1);
    check("t5_err_badk", err, ERR_EN);
    send(8'h01, 1'b0);
    check("t5_err_one_cycle", err, 1'b0);
    send(8'h02, 1'b0); send(8'h03, 1'b0);
    send(8'hBC, 1'b1);
    check("t5_err_com", err, 1'b0);
    send(8'h77, 1'b0);
    check("t5_err_data_in_os", err, ERR_EN);
    send(8'h1C, 1'b1);
    check("t5_err_clear", err, 1'b0);
    send(8'h1C, 1'b1);
    drain();

    // 3 lanes: lone byte padded into lanes 1..2
    exp3_q.push_back({3'b110, 24'hF7F75A});
    exp3_q.push_back(bc3(8'hBC));
    repeat (3) exp3_q.push_back(bc3(8'h1C));
    exp3_q.push_back({3'b000, 24'h030201});
    send3(8'h5A, 1'b0);
    send3(8'hBC, 1'b1);
    check("n3_pad_word", {lane_dk3, lane_data3}, {3'b110, 24'hF7F75A});
    repeat (3) send3(8'h1C, 1'b1);
    send3(8'h01, 1'b0); send3(8'h02, 1'b0); send3(8'h03, 1'b0);
    check("n3_lat_word", {lane_dk3, lane_data3}, {3'b000, 24'h030201});
    check("n3_err", err3, 1'b0);

    // 1 lane: every byte is its own word, no padding
    send1(8'hA5, 1'b0);
    send1(8'hBC, 1'b1);
    send1(8'h1C, 1'b1);
    send1(8'h1C, 1'b1);
    send1(8'h1C, 1'b1);
    send1(8'h5A, 1'b0);
    check("n1_err", err1, 1'b0);

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
